vme_bus_master: RTL and testbench

- Initiator for the single-cycle-strobe VME-style register bus.
- Drives VMEAddr, VMEWrData, VMERdMem and VMEWrMem; waits for Done/Error from a register-bank responder.
- Upstream command/response side is a valid/ready stream, so a sequencer, CPU bridge or test host can issue one transaction at a time.
- Sits between the control host and generated register banks; detects missing or errored responses and flags them with a timeout.

---
 rtl/vme_bus_master_pkg.sv | 12 +
 rtl/vme_timeout_cnt.sv | 32 +++
 rtl/vme_bus_master.sv | 151 +++++++++++++++
 tb/tb_vme_bus_master.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vme_bus_master_pkg.sv
// Shared types and constants for the VME register-bus initiator.
package vme_bus_master_pkg;

  typedef enum logic [1:0] {IDLE, STROBE, WAIT, RESP} state_t;

  localparam int unsigned DEFAULT_TIMEOUT = 255;

  function automatic int unsigned cnt_width(input int unsigned timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/vme_timeout_cnt.sv
// Saturating wait counter; expired flags the increment that reaches TIMEOUT.
module vme_timeout_cnt
  import vme_bus_master_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW = cnt_width(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] MAX  = CW'(TIMEOUT);

  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && count != MAX) begin
      count <= count + CW'(1);
    end
  end

  assign expired = enable && (count >= LAST);

endmodule

// File: rtl/vme_bus_master.sv
// Single-transaction initiator for the strobe/Done/Error register bus.
// Build option: define VME_BUS_MASTER_RETRY_EN to retry once after a responder error.
module vme_bus_master
  import vme_bus_master_pkg::*;
#(
  parameter int unsigned ADDR_HI = 19,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_HI:2]  cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic [ADDR_HI:2]  VMEAddr,
  output logic [DATA_W-1:0] VMEWrData,
  output logic              VMERdMem,
  output logic              VMEWrMem,
  input  logic [DATA_W-1:0] VMERdData,
  input  logic              VMERdDone,
  input  logic              VMEWrDone,
  input  logic              VMERdError,
  input  logic              VMEWrError
);

  state_t state, next_state;
  logic   dir;
  logic   accept, sampling, done_act, err_act, retry_go, expired;
  logic   cnt_clear, cnt_enable;

  logic              cmd_ready_d, rd_mem_d, wr_mem_d, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_d;
  logic              rsp_err_d, rsp_timeout_d;

  assign accept     = (state == IDLE) && cmd_valid && cmd_ready;
  assign sampling   = (state == STROBE) || (state == WAIT);
  assign done_act   = sampling && (dir ? VMEWrDone  : VMERdDone);
  assign err_act    = sampling && (dir ? VMEWrError : VMERdError);
  assign cnt_clear  = (state == STROBE);
  assign cnt_enable = (state == WAIT);

`ifdef VME_BUS_MASTER_RETRY_EN
  logic retried;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      retried <= 1'b0;
    end else if (accept) begin
      retried <= 1'b0;
    end else if (retry_go) begin
      retried <= 1'b1;
    end
  end

  assign retry_go = err_act && !retried;
`else
  assign retry_go = 1'b0;
`endif

  vme_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_cnt (
    .clk     (Clk),
    .rst     (Rst),
    .clear   (cnt_clear),
    .enable  (cnt_enable),
    .expired (expired)
  );

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:   if (accept) next_state = STROBE;
      STROBE,
      WAIT: begin
        if (retry_go)                      next_state = STROBE;
        else if (err_act || done_act)      next_state = RESP;
        else if (state == WAIT && expired) next_state = RESP;
        else                               next_state = WAIT;
      end
      RESP:   if (rsp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Outputs are registered, so their D-values are derived from next_state.
  always_comb begin
    cmd_ready_d   = (next_state == IDLE);
    rsp_valid_d   = (next_state == RESP);
    rd_mem_d      = 1'b0;
    wr_mem_d      = 1'b0;
    rsp_rdata_d   = rsp_rdata;
    rsp_err_d     = rsp_err;
    rsp_timeout_d = rsp_timeout;
    if (next_state == STROBE) begin
      rd_mem_d = accept ? !cmd_write : !dir;
      wr_mem_d = accept ?  cmd_write :  dir;
    end
    if (state == RESP && rsp_ready) begin
      rsp_rdata_d   = '0;
      rsp_err_d     = 1'b0;
      rsp_timeout_d = 1'b0;
    end else if (sampling && next_state == RESP) begin
      rsp_err_d     = err_act || !done_act;
      rsp_timeout_d = !err_act && !done_act;
      rsp_rdata_d   = (done_act && !err_act && !dir) ? VMERdData : '0;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      cmd_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      VMEAddr     <= '0;
      VMEWrData   <= '0;
      VMERdMem    <= 1'b0;
      VMEWrMem    <= 1'b0;
      dir         <= 1'b0;
    end else begin
      cmd_ready   <= cmd_ready_d;
      rsp_valid   <= rsp_valid_d;
      rsp_rdata   <= rsp_rdata_d;
      rsp_err     <= rsp_err_d;
      rsp_timeout <= rsp_timeout_d;
      VMERdMem    <= rd_mem_d;
      VMEWrMem    <= wr_mem_d;
      if (accept) begin
        VMEAddr   <= cmd_addr;
        VMEWrData <= cmd_wdata;
        dir       <= cmd_write;
      end
    end
  end

endmodule

// File: tb/tb_vme_bus_master.sv
// Self-checking bench for vme_bus_master: directed table, reset sequences, randomized transactions.
`define CHK(n, a, e) chk(n, 64'(a), 64'(e))

module tb_vme_bus_master;

  localparam int TMO = 8;
`ifdef VME_BUS_MASTER_RETRY_EN
  localparam bit RETRY = 1'b1;
`else
  localparam bit RETRY = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [19:2] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_err, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [19:2] VMEAddr;
  logic [31:0] VMEWrData, VMERdData = '0;
  logic        VMERdMem, VMEWrMem;
  logic        VMERdDone = 1'b0, VMEWrDone = 1'b0, VMERdError = 1'b0, VMEWrError = 1'b0;

  vme_bus_master #(.ADDR_HI(19), .DATA_W(32), .TIMEOUT(TMO)) dut (
    .Clk(clk), .Rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .VMEAddr(VMEAddr), .VMEWrData(VMEWrData), .VMERdMem(VMERdMem), .VMEWrMem(VMEWrMem),
    .VMERdData(VMERdData), .VMERdDone(VMERdDone), .VMEWrDone(VMEWrDone),
    .VMERdError(VMERdError), .VMEWrError(VMEWrError)
  );

  always #5 clk = ~clk;

  // kind: 0 = Done, 1 = Error, 2 = Error+Done, 3 = silent; d = cycles after strobe
  typedef struct {
    logic        wr;
    logic [17:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdval;
    int          kind;
    int          d;
    int          hold;
    logic [31:0] e_rdata;
    logic        e_err;
    logic        e_to;
    int          e_lat;
    int          e_str;
  } vec_t;

  int pass_cnt = 0, total_cnt = 0;

  logic        r_wr;
  logic [31:0] r_rdval;
  int          r_kind, r_resp_at, r_strobes;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic clear_resp();
    VMERdDone = 1'b0; VMEWrDone = 1'b0; VMERdError = 1'b0; VMEWrError = 1'b0;
  endtask

  task automatic drive_resp(input int c);
    int  k;
    logic dn, er;
    clear_resp();
    VMERdData = $urandom;
    if (r_wr) begin
      VMERdDone  = $urandom_range(1, 0) != 0;
      VMERdError = $urandom_range(1, 0) != 0;
    end else begin
      VMEWrDone  = $urandom_range(1, 0) != 0;
      VMEWrError = $urandom_range(1, 0) != 0;
    end
    if (c == r_resp_at) begin
      k  = (r_strobes >= 2) ? 0 : r_kind;
      dn = (k == 0) || (k == 2);
      er = (k == 1) || (k == 2);
      if (r_wr) begin
        VMEWrDone = dn; VMEWrError = er;
      end else begin
        VMERdDone = dn; VMERdError = er;
        VMERdData = r_rdval;
      end
    end
  endtask

  // Expected response computed from the bus rules, independent of the DUT's structure.
  function automatic vec_t model(input vec_t v);
    vec_t m = v;
    if (v.kind == 3 || v.d > TMO) begin
      m.e_rdata = '0; m.e_err = 1'b1; m.e_to = 1'b1; m.e_lat = TMO + 2; m.e_str = 1;
    end else if (v.kind == 0 || RETRY) begin
      m.e_rdata = v.wr ? 32'h0 : v.rdval; m.e_err = 1'b0; m.e_to = 1'b0;
      m.e_lat   = (v.kind == 0) ? v.d + 2 : 2 * v.d + 3;
      m.e_str   = (v.kind == 0) ? 1 : 2;
    end else begin
      m.e_rdata = '0; m.e_err = 1'b1; m.e_to = 1'b0; m.e_lat = v.d + 2; m.e_str = 1;
    end
    return m;
  endfunction

  task automatic run_txn(input vec_t v);
    int   c;
    bit   got, addr_ok, hold_ok, tail_ok;
    logic prev;
    clear_resp();
    `CHK("cmd_ready_idle", cmd_ready, 1'b1);
    cmd_valid = 1'b1; cmd_write = v.wr; cmd_addr = v.addr; cmd_wdata = v.wdata;
    r_wr = v.wr; r_kind = v.kind; r_rdval = v.rdval; r_resp_at = -100; r_strobes = 0;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_addr = 18'($urandom); cmd_wdata = $urandom;
    cmd_write = $urandom_range(1, 0) != 0;
    got = 1'b0; addr_ok = 1'b1; prev = 1'b0; c = 1;
    while (!got && c <= 60) begin
      if (rsp_valid) begin
        got = 1'b1;
      end else begin
        addr_ok &= (VMEAddr === v.addr);
        if (VMERdMem || VMEWrMem) begin
          r_strobes++;
          total_cnt++;
          if ({VMEWrMem, VMERdMem} === (v.wr ? 2'b10 : 2'b01)) pass_cnt++;
          else $display("FAIL strobe_dir: got %b wr=%b at %0t", {VMEWrMem, VMERdMem}, v.wr, $time);
          total_cnt++;
          if (prev === 1'b0) pass_cnt++;
          else $display("FAIL strobe_width: strobe held more than one cycle at %0t", $time);
          if (v.wr) `CHK("strobe_wdata", VMEWrData, v.wdata);
          r_resp_at = c + v.d;
        end
        prev = VMERdMem || VMEWrMem;
        drive_resp(c);
        @(negedge clk);
        c++;
      end
    end
    `CHK("rsp_arrived", got, 1'b1);
    if (!got) begin
      clear_resp();
      return;
    end
    total_cnt++;
    if (c == v.e_lat) pass_cnt++;
    else $display("FAIL rsp_latency: got %0d expected %0d at %0t", c, v.e_lat, $time);
    total_cnt++;
    if (rsp_rdata === v.e_rdata) pass_cnt++;
    else $display("FAIL rsp_rdata: got 0x%0h expected 0x%0h at %0t", rsp_rdata, v.e_rdata, $time);
    total_cnt++;
    if (rsp_err === v.e_err) pass_cnt++;
    else $display("FAIL rsp_err: got %b expected %b at %0t", rsp_err, v.e_err, $time);
    total_cnt++;
    if (rsp_timeout === v.e_to) pass_cnt++;
    else $display("FAIL rsp_timeout: got %b expected %b at %0t", rsp_timeout, v.e_to, $time);
    total_cnt++;
    if (r_strobes == v.e_str) pass_cnt++;
    else $display("FAIL strobe_count: got %0d expected %0d at %0t", r_strobes, v.e_str, $time);
    `CHK("addr_stable", addr_ok, 1'b1);
    hold_ok = 1'b1;
    for (int h = 0; h < v.hold; h++) begin
      cmd_valid = 1'b1;
      drive_resp(c);
      @(negedge clk);
      c++;
      hold_ok &= rsp_valid && (rsp_rdata === v.e_rdata) && (rsp_err === v.e_err) &&
                 (rsp_timeout === v.e_to) && !cmd_ready && !VMERdMem && !VMEWrMem;
    end
    if (v.hold > 0) `CHK("rsp_hold_stable", hold_ok, 1'b1);
    rsp_ready = 1'b1;
    drive_resp(c);
    @(negedge clk);
    c++;
    rsp_ready = 1'b0; cmd_valid = 1'b0;
    `CHK("rsp_valid_drop", rsp_valid, 1'b0);
    `CHK("cmd_ready_after", cmd_ready, 1'b1);
    tail_ok = 1'b1;
    while (c <= r_resp_at) begin
      drive_resp(c);
      @(negedge clk);
      c++;
      tail_ok &= !rsp_valid && !VMERdMem && !VMEWrMem;
    end
    `CHK("stray_ignored", tail_ok, 1'b1);
    clear_resp();
  endtask

  vec_t vecs[9];
  vec_t v;

  initial begin
    vecs[0] = '{1'b1, 18'h0,     32'h12345678, 32'h0,        0, 1, 0, 32'h0,        1'b0, 1'b0, 3,  1};
    vecs[1] = '{1'b0, 18'h1,     32'h0,        32'h00010203, 0, 1, 0, 32'h00010203, 1'b0, 1'b0, 3,  1};
    vecs[2] = '{1'b0, 18'h2,     32'h0,        32'h55AA55AA, 3, 0, 1, 32'h0,        1'b1, 1'b1, 10, 1};
    vecs[4] = '{1'b0, 18'h4,     32'h0,        32'hDEADBEEF, 0, 1, 5, 32'hDEADBEEF, 1'b0, 1'b0, 3,  1};
    vecs[5] = '{1'b0, 18'h5,     32'h0,        32'hCAFEF00D, 0, 0, 0, 32'hCAFEF00D, 1'b0, 1'b0, 2,  1};
    vecs[6] = '{1'b0, 18'h3FFFF, 32'h0,        32'h13572468, 0, 8, 0, 32'h13572468, 1'b0, 1'b0, 10, 1};
    vecs[7] = '{1'b0, 18'h6,     32'h0,        32'h24681357, 0, 9, 2, 32'h0,        1'b1, 1'b1, 10, 1};
`ifdef VME_BUS_MASTER_RETRY_EN
    vecs[3] = '{1'b1, 18'h3,     32'hA5A5A5A5, 32'h0,        2, 1, 0, 32'h0,        1'b0, 1'b0, 5,  2};
    vecs[8] = '{1'b0, 18'h7,     32'h0,        32'h11111111, 1, 2, 1, 32'h11111111, 1'b0, 1'b0, 7,  2};
`else
    vecs[3] = '{1'b1, 18'h3,     32'hA5A5A5A5, 32'h0,        2, 1, 0, 32'h0,        1'b1, 1'b0, 3,  1};
    vecs[8] = '{1'b0, 18'h7,     32'h0,        32'h11111111, 1, 2, 1, 32'h0,        1'b1, 1'b0, 4,  1};
`endif
    r_wr = 1'b0; r_rdval = '0; r_kind = 3; r_resp_at = -100; r_strobes = 0;

    #1;
    @(negedge clk); @(negedge clk);
    total_cnt++;
    if ({cmd_ready, rsp_valid, rsp_err, rsp_timeout, VMERdMem, VMEWrMem} === 6'b0) pass_cnt++;
    else $display("FAIL reset_outputs at %0t", $time);
    total_cnt++;
    if (rsp_rdata === 32'h0) pass_cnt++;
    else $display("FAIL reset_rdata: got 0x%0h at %0t", rsp_rdata, $time);
    total_cnt++;
    if ({VMEAddr, VMEWrData} === 50'h0) pass_cnt++;
    else $display("FAIL reset_addr_data at %0t", $time);
    rst = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (cmd_ready === 1'b1) pass_cnt++;
    else $display("FAIL cmd_ready_post_reset at %0t", $time);

    foreach (vecs[i]) run_txn(vecs[i]);

    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 18'h9;
    @(negedge clk);
    cmd_valid = 1'b0;
    `CHK("pre_reset_strobe", VMERdMem, 1'b1);
    #2 rst = 1'b1;
    #1 `CHK("reset_strobe_drop", {VMERdMem, VMEWrMem, rsp_valid, cmd_ready}, 4'b0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    `CHK("reset_cmd_lost", {cmd_ready, rsp_valid, VMERdMem}, 3'b100);

    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 18'hA; cmd_wdata = 32'h0BADF00D;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    #2 rst = 1'b1;
    #1 `CHK("reset_wait_outputs", {VMERdMem, VMEWrMem, rsp_valid, cmd_ready, VMEAddr}, 22'h0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk); @(negedge clk);
    `CHK("reset_wait_idle", {cmd_ready, rsp_valid}, 2'b10);
    v = '{1'b0, 18'h1234, 32'h0, 32'h89ABCDEF, 0, 1, 0, 32'h0, 1'b0, 1'b0, 0, 0};
    run_txn(model(v));

    for (int n = 0; n < 40; n++) begin
      v.wr    = $urandom_range(1, 0) != 0;
      v.addr  = 18'($urandom);
      v.wdata = $urandom;
      v.rdval = $urandom;
      v.kind  = $urandom_range(3, 0);
      v.d     = $urandom_range(TMO + 3, 0);
      v.hold  = $urandom_range(3, 0);
      if (RETRY && (v.kind == 1 || v.kind == 2) && v.d == 0) v.d = 1;
      run_txn(model(v));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", pass_cnt, total_cnt);
    $fatal(1, "watchdog");
  end

endmodule
